// File: rtl/ring_pkg.sv
// Shared definitions for the left and right rotating rings.
// Default ring length plus rotate and one-hot helpers.
package ring_pkg;

  localparam int RING_WIDTH_DEFAULT = 6;

  // Rotate right by one within the low w bits of v.
  function automatic logic [31:0] rotr(
    input logic [31:0] v,
    input int unsigned w
  );
    logic [31:0] m;
    logic [31:0] top;
    m   = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    top = v[0] ? (32'd1 << (w - 1)) : 32'd0;
    return ((v & m) >> 1 | top) & m;
  endfunction

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(
    input logic [31:0] v
  );
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/ring_cell.sv
// One ring bit: async-clear flop with load/shift/hold mux.
// Load wins over shift; otherwise the bit holds.
module ring_cell
  import ring_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_shift,
  input  logic i_din,
  input  logic i_next,
  output logic o_q
);

  logic r_q;

  // Select parallel load, neighbour bit, or hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_q <= 1'b0;
    else if (i_load)  r_q <= i_din;
    else if (i_shift) r_q <= i_next;
  end

  assign o_q = r_q;

endmodule

// File: rtl/ring_shift_register_right_6bit.sv
// Rotate-right ring with load, position counter and wrap pulse.
// Define RING_ONEHOT_CHECK_EN to build the sticky one-hot checker.
module ring_shift_register_right_6bit
  import ring_pkg::*;
#(
  parameter int WIDTH = RING_WIDTH_DEFAULT,
  parameter int POS_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             shift_en,
  output logic [WIDTH-1:0] q,
  output logic [POS_W-1:0] pos,
  output logic             wrap,
  output logic             onehot_err
);

  localparam logic [POS_W-1:0] LAST = POS_W'(WIDTH - 1);

  logic [WIDTH-1:0] w_q;
  logic [POS_W-1:0] r_pos;
  logic             r_wrap;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ring_cell u_cell (
      .clk     (clk),
      .reset   (reset),
      .i_load  (load),
      .i_shift (shift_en),
      .i_din   (din[i]),
      .i_next  (w_q[(i + 1) % WIDTH]),
      .o_q     (w_q[i])
    );
  end

  // Count rotations since load; pulse wrap on return to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pos  <= '0;
      r_wrap <= 1'b0;
    end else if (load) begin
      r_pos  <= '0;
      r_wrap <= 1'b0;
    end else if (shift_en) begin
      r_wrap <= (r_pos == LAST);
      r_pos  <= (r_pos == LAST) ? '0 : r_pos + POS_W'(1);
    end else begin
      r_wrap <= 1'b0;
    end
  end

`ifdef RING_ONEHOT_CHECK_EN
  logic r_loaded;
  logic r_err;

  // Sticky flag; a load re-evaluates it against the new contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_loaded <= 1'b0;
      r_err    <= 1'b0;
    end else if (load) begin
      r_loaded <= 1'b1;
      r_err    <= !is_onehot(32'(din));
    end else if (r_loaded && !is_onehot(32'(w_q))) begin
      r_err    <= 1'b1;
    end
  end

  assign onehot_err = r_err;
`else
  assign onehot_err = 1'b0;
`endif

  assign q    = w_q;
  assign pos  = r_pos;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_ring_shift_register_right_6bit.sv
// Directed bench for the rotate-right ring.
// Expected values are hand-computed constants.
module tb_ring_shift_register_right_6bit;

`ifdef RING_ONEHOT_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [5:0] din = '0;
  logic       shift_en = 1'b0;
  logic [5:0] q;
  logic [2:0] pos;
  logic       wrap;
  logic       onehot_err;

  int n_chk = 0;
  int n_fail = 0;

  ring_shift_register_right_6bit dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .din        (din),
    .shift_en   (shift_en),
    .q          (q),
    .pos        (pos),
    .wrap       (wrap),
    .onehot_err (onehot_err)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(
    input string      tag,
    input logic [5:0] eq,
    input logic [2:0] ep,
    input logic       ew,
    input logic       ee
  );
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".pos"}, 32'(pos), 32'(ep));
    chk({tag, ".wrap"}, 32'(wrap), 32'(ew));
    chk({tag, ".err"}, 32'(onehot_err), 32'(ee));
  endtask

  initial begin
    step();
    step();
    reset = 1'b0;

    // Prime nonzero state, then reset between edges.
    din = 6'b110101; load = 1'b1; step(); load = 1'b0;
    shift_en = 1'b1; step(); shift_en = 1'b0;
    chk("preload.q", 32'(q), 32'(6'b111010));
    #3 reset = 1'b1;
    #1 chk_all("async_rst", 6'b000000, 3'd0, 1'b0, 1'b0);
    step();
    reset = 1'b0;

    // Load one-hot and shift twice.
    din = 6'b000001; load = 1'b1; step(); load = 1'b0;
    chk_all("ld1", 6'b000001, 3'd0, 1'b0, 1'b0);
    shift_en = 1'b1;
    step(); chk_all("sh1", 6'b100000, 3'd1, 1'b0, 1'b0);
    step(); chk_all("sh2", 6'b010000, 3'd2, 1'b0, 1'b0);
    shift_en = 1'b0;

    // Full rotation with wrap pulse.
    din = 6'b101100; load = 1'b1; step(); load = 1'b0;
    chk_all("ldrot", 6'b101100, 3'd0, 1'b0, ERR_EN);
    shift_en = 1'b1;
    step(); chk_all("rot1", 6'b010110, 3'd1, 1'b0, ERR_EN);
    step(); chk_all("rot2", 6'b001011, 3'd2, 1'b0, ERR_EN);
    step(); chk_all("rot3", 6'b100101, 3'd3, 1'b0, ERR_EN);
    step(); chk_all("rot4", 6'b110010, 3'd4, 1'b0, ERR_EN);
    step(); chk_all("rot5", 6'b011001, 3'd5, 1'b0, ERR_EN);
    step(); chk_all("rot6", 6'b101100, 3'd0, 1'b1, ERR_EN);
    step(); chk_all("rot7", 6'b010110, 3'd1, 1'b0, ERR_EN);
    shift_en = 1'b0;
    step(); chk_all("rotidle", 6'b010110, 3'd1, 1'b0, ERR_EN);

    // Two-hot load, walk to pos 5, then load+shift together.
    din = 6'b000110; load = 1'b1; step(); load = 1'b0;
    chk_all("ld2hot", 6'b000110, 3'd0, 1'b0, ERR_EN);
    shift_en = 1'b1;
    step(); step(); step(); step(); step();
    chk_all("pos5", 6'b001100, 3'd5, 1'b0, ERR_EN);
    din = 6'b000011; load = 1'b1;
    step(); load = 1'b0; shift_en = 1'b0;
    chk_all("prio", 6'b000011, 3'd0, 1'b0, ERR_EN);

    // One-hot load clears the flag; then hold test.
    din = 6'b001000; load = 1'b1; step(); load = 1'b0;
    chk_all("ldoh", 6'b001000, 3'd0, 1'b0, 1'b0);
    shift_en = 1'b1;
    step(); step(); step();
    shift_en = 1'b0;
    chk_all("sh3", 6'b000001, 3'd3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_all("hold", 6'b000001, 3'd3, 1'b0, 1'b0);
    end

    // Reset mid-rotation, then shift the empty ring.
    #3 reset = 1'b1;
    #1 chk_all("rst_mid", 6'b000000, 3'd0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    shift_en = 1'b1;
    step(); chk_all("zero1", 6'b000000, 3'd1, 1'b0, 1'b0);
    step(); chk_all("zero2", 6'b000000, 3'd2, 1'b0, 1'b0);
    step(); chk_all("zero3", 6'b000000, 3'd3, 1'b0, 1'b0);
    shift_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
